// File: rtl/activity_monitor.sv
// activity_monitor: per-second step statistics computed from the one-cycle PULSE stream.
//
// Ports:
//   CLK         in   system clock
//   RESET       in   synchronous, active-low reset (highest priority)
//   PULSE       in   one-cycle step pulse
//   CLEAR       in   synchronous statistics clear, active-high
//   RATE        out  steps counted in the last completed second
//   RATE_VALID  out  one-cycle strobe when RATE updates
//   PEAK_RATE   out  maximum RATE since reset/clear
//   HIGH_SECS   out  completed seconds with rate >= HIGH_THRESH
//   WIN_STEPS   out  steps in the first WINDOW seconds of activity
//   WIN_DONE    out  high once the window has closed
//   ACTIVE      out  high while the FSM is in RUN
module activity_monitor #(
  parameter int unsigned CLK_PER_SEC = 100000000,
  parameter int unsigned HIGH_THRESH = 64,
  parameter int unsigned WINDOW      = 9,
  parameter int unsigned IDLE_SECS   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PULSE,
  input  logic        CLEAR,
  output logic [13:0] RATE,
  output logic        RATE_VALID,
  output logic [13:0] PEAK_RATE,
  output logic [13:0] HIGH_SECS,
  output logic [13:0] WIN_STEPS,
  output logic        WIN_DONE,
  output logic        ACTIVE
);

  localparam int unsigned TW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int unsigned SW = $clog2(WINDOW + 1);
  localparam int unsigned ZW = $clog2(IDLE_SECS + 1);

  localparam logic [13:0] ACC_MAX = 14'd16383;
  localparam logic [13:0] BCD_MAX = 14'd9999;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [13:0]   acc;
  logic [SW-1:0] sec_cnt;
  logic [ZW-1:0] zero_cnt;

  logic [13:0] r_c;
  logic [13:0] win_inc_c;
  logic [13:0] high_inc_c;
  logic        tick_c;
  logic        win_open_c;

  // Saturating next values and the closing-second rate (includes a pulse on the tick itself)
  always_comb begin
    r_c        = acc;
    win_inc_c  = WIN_STEPS;
    high_inc_c = HIGH_SECS;
    if (PULSE && (acc != ACC_MAX))
      r_c = acc + 14'd1;
    if (WIN_STEPS != BCD_MAX)
      win_inc_c = WIN_STEPS + 14'd1;
    if (HIGH_SECS != BCD_MAX)
      high_inc_c = HIGH_SECS + 14'd1;
    tick_c     = (state == S_RUN) && (tick_cnt == TW'(CLK_PER_SEC - 1));
    win_open_c = (sec_cnt < SW'(WINDOW));
  end

  // Control FSM, counters and registered statistics
  always_ff @(posedge CLK) begin
    if (!RESET || CLEAR) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      acc        <= '0;
      sec_cnt    <= '0;
      zero_cnt   <= '0;
      RATE       <= '0;
      RATE_VALID <= 1'b0;
      PEAK_RATE  <= '0;
      HIGH_SECS  <= '0;
      WIN_STEPS  <= '0;
      WIN_DONE   <= 1'b0;
      ACTIVE     <= 1'b0;
    end else begin
      RATE_VALID <= 1'b0;
      if (state == S_IDLE) begin
        // The waking pulse counts as cycle 0 of the first second
        if (PULSE) begin
          state    <= S_RUN;
          ACTIVE   <= 1'b1;
          tick_cnt <= TW'(1);
          acc      <= 14'd1;
          if (win_open_c)
            WIN_STEPS <= win_inc_c;
        end
      end else begin
        if (PULSE && win_open_c)
          WIN_STEPS <= win_inc_c;
        if (tick_c) begin
          tick_cnt   <= '0;
          acc        <= '0;
          RATE       <= r_c;
          RATE_VALID <= 1'b1;
          if (r_c > PEAK_RATE)
            PEAK_RATE <= r_c;
          if (r_c >= 14'(HIGH_THRESH))
            HIGH_SECS <= high_inc_c;
          if (win_open_c) begin
            sec_cnt <= sec_cnt + SW'(1);
            if (sec_cnt == SW'(WINDOW - 1))
              WIN_DONE <= 1'b1;
          end
          // Enough consecutive empty seconds drop back to IDLE; stats are kept
          if (r_c == 14'd0) begin
            if (zero_cnt == ZW'(IDLE_SECS - 1)) begin
              state    <= S_IDLE;
              ACTIVE   <= 1'b0;
              zero_cnt <= '0;
            end else begin
              zero_cnt <= zero_cnt + ZW'(1);
            end
          end else begin
            zero_cnt <= '0;
          end
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
          acc      <= r_c;
        end
      end
    end
  end

endmodule
